// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: start bit, N data bits MSB first, optional even-parity bit.
// Optional parity stage enabled by defining SHIFT_DESER_PARITY_EN.
`ifndef SHIFT_LEN
`define SHIFT_LEN 8
`endif
module shift_deser #(
    parameter int N = `SHIFT_LEN
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sin,
    input  logic         bit_en,
    output logic [N-1:0] data_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         overrun,
    output logic         parity_err
);

    localparam int CW = $clog2(N + 1);
`ifdef SHIFT_DESER_PARITY_EN
    localparam int SW = N;
`else
    // The final data bit goes straight from sin into the word, so one bit less is stored.
    localparam int SW = N - 1;
`endif
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [SW-1:0]   shreg_r;
    logic [N-1:0]    data_r;
    logic            valid_r;
    logic            busy_r;
    logic            overrun_r;
    logic            complete_s;
    logic [N-1:0]    word_s;

`ifdef SHIFT_DESER_PARITY_EN
    logic            perr_r;
    logic            perr_s;

    function automatic logic even_parity_err(input logic [N:0] bits);
        return ^bits;
    endfunction

    // Word completes on the qualified parity sample.
    always_comb begin
        complete_s = 1'b0;
        word_s     = shreg_r;
        perr_s     = 1'b0;
        if (bit_en && (state_r == ST_PARITY)) begin
            complete_s = 1'b1;
            perr_s     = even_parity_err({shreg_r, sin});
        end else begin
            complete_s = 1'b0;
        end
    end
`else
    // Word completes on the qualified sample of the last data bit.
    always_comb begin
        complete_s = 1'b0;
        word_s     = N'({shreg_r, sin});
        if (bit_en && (state_r == ST_DATA) && (cnt_r == LAST_BIT)) begin
            complete_s = 1'b1;
        end else begin
            complete_s = 1'b0;
        end
    end
`endif

    // Frame FSM: start detection, data shifting and bit counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            shreg_r <= '0;
            busy_r  <= 1'b0;
        end else if (bit_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (sin) begin
                        state_r <= ST_DATA;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                ST_DATA: begin
                    shreg_r <= SW'({shreg_r, sin});
                    cnt_r   <= cnt_r + CW'(1);
                    if (cnt_r == LAST_BIT) begin
`ifdef SHIFT_DESER_PARITY_EN
                        state_r <= ST_PARITY;
                        busy_r  <= 1'b1;
`else
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
`endif
                    end
                end
                ST_PARITY: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register with valid/ready handshake and overrun detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r    <= '0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
            perr_r    <= 1'b0;
`endif
        end else begin
            overrun_r <= 1'b0;
            if (complete_s) begin
                if (!valid_r || out_ready) begin
                    data_r  <= word_s;
                    valid_r <= 1'b1;
`ifdef SHIFT_DESER_PARITY_EN
                    perr_r  <= perr_s;
`endif
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (valid_r && out_ready) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign data_out  = data_r;
    assign out_valid = valid_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;
`ifdef SHIFT_DESER_PARITY_EN
    assign parity_err = perr_r;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deser.sv
// Randomized self-checking bench for shift_deser (N=8) against a frame-level reference model.
module tb_shift_deser;

    localparam int N = 8;
`ifdef SHIFT_DESER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sin = 1'b0;
    logic         bit_en = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] data_out;
    logic         out_valid;
    logic         busy;
    logic         overrun;
    logic         parity_err;

    int n_checks = 0;
    int n_errors = 0;
    int ov_seen  = 0;

    // Reference model: frame progress as plain integers.
    int   m_phase = -1;
    int   m_word  = 0;
    logic exp_valid = 1'b0;
    int   exp_data  = 0;
    logic exp_over  = 1'b0;
    logic exp_perr  = 1'b0;
    logic exp_busy  = 1'b0;

    shift_deser #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .bit_en    (bit_en),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic odd_weight(input int v, input logic extra);
        int ones = (extra ? 1 : 0);
        for (int i = 0; i < N; i++) ones += (v >> i) & 1;
        return (ones % 2) == 1;
    endfunction

    task automatic step(input logic s, input logic e, input logic r, input logic rst);
        logic comp = 1'b0;
        int   cw = 0;
        logic cp = 1'b0;
        sin = s; bit_en = e; out_ready = r; reset = rst;
        @(posedge clk);
        if (rst) begin
            m_phase = -1; m_word = 0;
            exp_valid = 1'b0; exp_data = 0; exp_over = 1'b0; exp_perr = 1'b0;
        end else begin
            exp_over = 1'b0;
            if (e) begin
                if (m_phase < 0) begin
                    if (s) begin m_phase = 0; m_word = 0; end
                end else if (m_phase < N) begin
                    m_word = m_word * 2 + (s ? 1 : 0);
                    m_phase++;
                    if (m_phase == N && !PAR) begin
                        comp = 1'b1; cw = m_word; cp = 1'b0; m_phase = -1;
                    end
                end else begin
                    comp = 1'b1; cw = m_word; cp = odd_weight(m_word, s); m_phase = -1;
                end
            end
            if (comp) begin
                if (!exp_valid || r) begin
                    exp_valid = 1'b1; exp_data = cw; exp_perr = cp;
                end else begin
                    exp_over = 1'b1;
                end
            end else if (exp_valid && r) begin
                exp_valid = 1'b0;
            end
        end
        exp_busy = (m_phase >= 0);
        #1;
        if (overrun) ov_seen++;
        chk_eq("out_valid", 32'(out_valid), 32'(exp_valid));
        chk_eq("data_out", 32'(data_out), 32'(exp_data));
        chk_eq("busy", 32'(busy), 32'(exp_busy));
        chk_eq("overrun", 32'(overrun), 32'(exp_over));
        chk_eq("parity_err", 32'(parity_err), 32'(exp_perr));
    endtask

    // en_mode: 0 contiguous, 1 alternate disabled cycle, 2 random gaps.
    // rmode: 0 ready low, 1 ready high, 2 random, 3 high only on the final bit.
    task automatic send_frame(input logic [7:0] w, input int en_mode, input int rmode,
                              input logic force_pb, input logic pb);
        logic bits[$];
        logic r;
        bits.push_back(1'b1);
        for (int i = N - 1; i >= 0; i--) bits.push_back(w[i]);
        if (PAR) bits.push_back(force_pb ? pb : ^w);
        for (int i = 0; i < bits.size(); i++) begin
            case (rmode)
                0: r = 1'b0;
                1: r = 1'b1;
                2: r = ($urandom_range(0, 1) == 1);
                default: r = (i == bits.size() - 1);
            endcase
            if (en_mode == 1) step(($urandom_range(0, 1) == 1), 1'b0, (rmode == 3) ? 1'b0 : r, 1'b0);
            if (en_mode == 2) begin
                while ($urandom_range(0, 3) == 0)
                    step(($urandom_range(0, 1) == 1), 1'b0, (rmode == 3) ? 1'b0 : r, 1'b0);
            end
            step(bits[i], 1'b1, r, 1'b0);
        end
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk_eq("reset_valid", 32'(out_valid), 32'd0);
        chk_eq("reset_data", 32'(data_out), 32'd0);

        // Contiguous frame
        send_frame(8'hAA, 0, 0, 1'b0, 1'b0);
        chk_eq("aa_data", 32'(data_out), 32'h0000_00AA);
        chk_eq("aa_valid", 32'(out_valid), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0);

        // Alternating qualifier
        send_frame(8'h3C, 1, 0, 1'b0, 1'b0);
        chk_eq("3c_data", 32'(data_out), 32'h0000_003C);
        step(1'b0, 1'b1, 1'b1, 1'b0);

        // Overrun: second word dropped
        ov_seen = 0;
        send_frame(8'hAA, 0, 0, 1'b0, 1'b0);
        send_frame(8'h55, 0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_eq("ovr_data", 32'(data_out), 32'h0000_00AA);
        chk_eq("ovr_count", 32'(ov_seen), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0);

        // Back-to-back completion with consume
        send_frame(8'hAA, 0, 0, 1'b0, 1'b0);
        ov_seen = 0;
        send_frame(8'h55, 0, 3, 1'b0, 1'b0);
        chk_eq("b2b_data", 32'(data_out), 32'h0000_0055);
        chk_eq("b2b_valid", 32'(out_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_eq("b2b_ovr", 32'(ov_seen), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0);

        // Reset mid-frame
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk_eq("midrst_busy", 32'(busy), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h0F, 0, 0, 1'b0, 1'b0);
        chk_eq("0f_data", 32'(data_out), 32'h0000_000F);
        step(1'b0, 1'b1, 1'b1, 1'b0);

        if (PAR) begin
            send_frame(8'hAA, 0, 0, 1'b1, 1'b0);
            chk_eq("par_ok", 32'(parity_err), 32'd0);
            step(1'b0, 1'b1, 1'b1, 1'b0);
            send_frame(8'hAA, 0, 0, 1'b1, 1'b1);
            chk_eq("par_bad", 32'(parity_err), 32'd1);
            step(1'b0, 1'b1, 1'b1, 1'b0);
        end

        // Idle line
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, ($urandom_range(0, 1) == 1), 1'b0);
        chk_eq("idle_busy", 32'(busy), 32'd0);
        chk_eq("idle_valid", 32'(out_valid), 32'd0);

        // Randomized traffic
        for (int f = 0; f < 150; f++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b1, ($urandom_range(0, 1) == 1), 1'b0);
            if ($urandom_range(0, 39) == 0) step(1'b0, 1'b1, 1'b0, 1'b1);
            send_frame(8'($urandom), 2, 2, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_deser.md
# shift_deser

Serial-to-parallel receiver for the bit stream produced by the `shiftreg` serial output (`sout`, MSB first, one bit per qualified clock). It detects a start bit, shifts in `N` data bits, optionally checks a parity bit, and presents the recovered word on a parallel port with a valid/ready handshake. It sits at the far end of the serial link in the datapath and is the counterpart to the parallel-load shift register.

## Interface

Parameters:
- `N`, default `` `SHIFT_LEN `` (8 when the macro is undefined): data word width. Legal range is `N` ≥ 2.

Ports:
- `clk`  input  1  clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `sin`  input  1  serial data in; connects to the transmitter `sout`.
- `bit_en`  input  1  sample qualifier. `sin` is sampled only on edges where `bit_en`=1.
- `data_out`  output  N  received word, MSB = first data bit.
- `out_valid`  output  1  `data_out` holds an unconsumed word.
- `out_ready`  input  1  consumer accepts the word when `out_valid`=1 and `out_ready`=1.
- `busy`  output  1  a frame is in progress (state ≠ IDLE).
- `overrun`  output  1  one-cycle pulse: a completed word was dropped.
- `parity_err`  output  1  parity check result for the word on `data_out`.

## Operation

- Frame format: start bit (`sin`=1), then `N` data bits MSB first, then one even-parity bit (only with `SHIFT_DESER_PARITY_EN`). There is no stop bit; idle line is 0.
- States:
  - IDLE: on a qualified sample with `sin`=1, go to DATA and clear the bit counter. `sin`=0 stays in IDLE.
  - DATA: each qualified sample performs `shreg <= {shreg[N-2:0], sin}` and increments the counter. After the `N`th bit, go to PARITY if the macro is enabled, otherwise complete the word and return to IDLE.
  - PARITY: on a qualified sample, compute `parity_err = ^{shreg, sin}` (even parity), complete the word, and return to IDLE.
- `bit_en`=0 freezes the state, counter and `shreg`. The output handshake still operates.
- The counter is `$clog2(N+1)` bits wide. It never wraps inside a frame.
- Word completion:
  - If `out_valid`=0, or `out_ready`=1 in the same cycle: load `data_out`/`parity_err` and set `out_valid`=1.
  - Otherwise, drop the new word, keep the old word, and pulse `overrun`=1 for one cycle.
- Consume: if `out_valid`=1 and `out_ready`=1 with no completion in that cycle, `out_valid` drops to 0 and `data_out` holds its last value.
- A completion that coincides with a consume is back-to-back: `out_valid` stays 1 and the new word is loaded.
- A start bit can be accepted on the qualified sample right after the last data or parity bit. No idle gap is required.

## Timing

- Reset values: `data_out`=0, `out_valid`=0, `busy`=0, `overrun`=0, `parity_err`=0. State returns to IDLE and `shreg`/counter are cleared.
- Reset mid-frame abandons the frame. No word is delivered.
- With `bit_en` held at 1, the start bit is sampled at edge E0 and the data bits at E1..EN:
  - Without parity: `out_valid` rises after EN, so it is visible in the cycle following EN.
  - With parity: the parity bit is sampled at EN+1 and `out_valid` rises after EN+1.
- `busy` is 1 from the cycle after E0 through the cycle in which the last bit is sampled. It is 0 after completion.
- `overrun` is registered and asserted for exactly one cycle, in the cycle after the completing edge.
- `out_ready` is a don't-care while `out_valid`=0.

## Configuration

- `SHIFT_DESER_PARITY_EN` defined:
  - PARITY state is present and the frame is `N`+2 bits long.
  - `parity_err`=1 when the data bits plus the parity bit have odd weight.
- Not defined:
  - No PARITY state; the frame is `N`+1 bits long.
  - The `parity_err` port remains but is tied to 0.

## Test plan

All cases use `N`=8.
- Reset, then send start, 10101010 with `bit_en`=1 and `out_ready`=0 → `out_valid`=1 one cycle after the 8th data bit, `data_out`=8'hAA, `busy`=0, `overrun`=0.
- `bit_en` toggling 1/0 every cycle while sending 8'h3C → result is identical to the contiguous case. `out_valid` asserts after the 8th qualified sample, and state/`shreg` are unchanged on the `bit_en`=0 edges.
- Hold `out_ready`=0 and send 8'hAA then 8'h55 back-to-back → `data_out` stays 8'hAA and `overrun` pulses once. Repeat with `out_ready`=1 at the second completion → `data_out`=8'h55, `out_valid` stays 1, no `overrun`.
- Assert `reset` after 4 data bits, release it, then send 8'h0F → only 8'h0F is delivered, and every output reads its reset value during the reset cycle.
- With `SHIFT_DESER_PARITY_EN`: send 8'hAA with parity bit 0, then 8'hAA with parity bit 1 → `parity_err`=0 for the first word and 1 for the second, each delivered one cycle after its parity bit.
- `sin`=0 for 20 cycles after reset → state stays IDLE, `busy`=0, `out_valid`=0.
